// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB3 command master.
// Timeout feature is enabled with `define APB_CMD_MASTER_TIMEOUT_EN.
package apb_cmd_master_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  localparam logic [APB_DW-1:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic [APB_AW-1:0] word_align(input logic [APB_AW-1:0] addr);
    return {addr[APB_AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/apb_cmd_master_timer.sv
// ACCESS-phase stall counter: load clears it, count advances it, expire flags
// the TIMEOUT_CYCLES-th consecutive counted cycle.
module apb_cmd_master_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB3 requester bridge.
// Optional ACCESS timeout: `define APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [APB_AW-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [APB_DW-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_AW-1:0] PADDR,
  output logic [APB_DW-1:0] PWDATA,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  state_e            state_q;
  logic              ready_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [APB_AW-1:0] paddr_q;
  logic [APB_DW-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [APB_DW-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              timeout;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be within 2..65535");
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_cmd_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .load_i  (state_q == ST_SETUP),
    .count_i ((state_q == ST_ACCESS) && !PREADY),
    .expire_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q  <= ST_SETUP;
            ready_q  <= 1'b0;
            psel_q   <= 1'b1;
            paddr_q  <= word_align(cmd_addr);
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
        end
        ST_ACCESS: begin
          // A completing PREADY wins over a timeout landing on the same cycle.
          if (PREADY) begin
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            rsp_err_q   <= PSLVERR;
          end else if (timeout) begin
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= TIMEOUT_RDATA;
            rsp_err_q   <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ready_q resets high; gating with PRESETn keeps it low while reset is held.
  assign cmd_ready = ready_q & PRESETn;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: vector table plus timeout/stall and reset sequences.
`timescale 1ns/1ps
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int n_vec = 0;
  int n_err = 0;

  apb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Memory completer: 16 words, write on the completing ACCESS edge.
  logic [31:0] mem [16];
  assign PRDATA = mem[PADDR[5:2]];
  always @(posedge PCLK)
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;
    logic        slverr;
    int unsigned hold;
    logic [31:0] exp_paddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h5555_5555;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned acc;
    int unsigned edges;
    bit          stable;
    logic [31:0] exp_pw;
    exp_pw = v.wr ? v.wdata : 32'h0;
    n_vec++;
    chk($sformatf("v%0d idle cmd_ready", idx), {31'b0, cmd_ready}, 32'd1);
    start_cmd(v.wr, v.addr, v.wdata);
    edges = 1;
    chk($sformatf("v%0d setup PSEL", idx), {31'b0, PSEL}, 32'd1);
    chk($sformatf("v%0d setup PENABLE", idx), {31'b0, PENABLE}, 32'd0);
    chk($sformatf("v%0d setup cmd_ready", idx), {31'b0, cmd_ready}, 32'd0);
    chk($sformatf("v%0d setup PADDR", idx), PADDR, v.exp_paddr);
    chk($sformatf("v%0d setup PWRITE", idx), {31'b0, PWRITE}, {31'b0, v.wr});
    chk($sformatf("v%0d setup PWDATA", idx), PWDATA, exp_pw);
    PREADY = 1'b0; PSLVERR = 1'b0;
    acc = 0; stable = 1'b1;
    while (acc < 200) begin
      @(posedge PCLK); #1;
      edges++;
      if (!(PSEL && PENABLE)) break;
      acc++;
      if (PADDR !== v.exp_paddr || PWDATA !== exp_pw || PWRITE !== v.wr) stable = 1'b0;
      PREADY  = (acc > v.waits);
      PSLVERR = PREADY ? v.slverr : 1'b0;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    chk($sformatf("v%0d access cycles", idx), acc, v.waits + 1);
    chk($sformatf("v%0d edges to rsp", idx), edges, v.waits + 3);
    chk($sformatf("v%0d access stable", idx), {31'b0, stable}, 32'd1);
    chk($sformatf("v%0d rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d resp PSEL", idx), {31'b0, PSEL}, 32'd0);
    chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
    for (int unsigned h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1; cmd_addr = 32'h0000_0030; cmd_write = 1'b1;
      rsp_ready = 1'b0;
      @(posedge PCLK); #1;
      chk($sformatf("v%0d hold%0d rsp_valid", idx, h), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d hold%0d rsp_rdata", idx, h), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d hold%0d rsp_err", idx, h), {31'b0, rsp_err}, {31'b0, v.exp_err});
      chk($sformatf("v%0d hold%0d cmd_ready", idx, h), {31'b0, cmd_ready}, 32'd0);
      chk($sformatf("v%0d hold%0d PSEL", idx, h), {31'b0, PSEL}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk($sformatf("v%0d post rsp_valid", idx), {31'b0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d post cmd_ready", idx), {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int unsigned acc;
    bit          bad;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    //            wr    addr          wdata         wt slv hold paddr         rdata         err
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 0, 1'b0, 0, 32'h0000_0010, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0013, 32'h1111_1111, 0, 1'b0, 0, 32'h0000_0010, 32'hA5A5_1234, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0024, 32'hDEAD_BEEF, 5, 1'b0, 0, 32'h0000_0024, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0026, 32'h0000_0000, 2, 1'b0, 0, 32'h0000_0024, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 1'b1, 4, 32'h0000_0010, 32'hA5A5_1234, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_003F, 32'h0BAD_F00D, 1, 1'b1, 2, 32'h0000_003C, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_003C, 32'h0000_0000, 3, 1'b0, 1, 32'h0000_003C, 32'h0BAD_F00D, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 0, 1'b0, 0, 32'h0000_0004, 32'h0000_0000, 1'b0};

    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset state
    n_vec++;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst PSEL", {31'b0, PSEL}, 32'd0);
    chk("rst PENABLE", {31'b0, PENABLE}, 32'd0);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst PADDR", PADDR, 32'h0);
    chk("rst PWDATA", PWDATA, 32'h0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    #1;
    chk("rel cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // rsp_ready and PREADY in IDLE have no effect
    n_vec++;
    rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("idle rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("idle PSEL", {31'b0, PSEL}, 32'd0);
    chk("idle cmd_ready", {31'b0, cmd_ready}, 32'd1);
    rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // Timeout: PREADY stuck low, 8 ACCESS cycles then abort response
    n_vec++;
    start_cmd(1'b0, 32'h0000_0020, 32'h0);
    acc = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge PCLK); #1;
      if (!(PSEL && PENABLE)) break;
      acc++;
    end
    chk("tmo access cycles", acc, 32'd8);
    chk("tmo rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("tmo rsp_err", {31'b0, rsp_err}, 32'd1);
    chk("tmo rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
    chk("tmo PSEL", {31'b0, PSEL}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk("tmo post cmd_ready", {31'b0, cmd_ready}, 32'd1);
    n_vec++;
    start_cmd(1'b1, 32'h0000_0008, 32'h1234_5678);
    repeat (4) @(posedge PCLK);
    #1;
`else
    // No timeout: PREADY stuck low keeps the transfer in ACCESS
    n_vec++;
    start_cmd(1'b1, 32'h0000_0008, 32'h1234_5678);
    bad = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(posedge PCLK); #1;
      if (!(PSEL && PENABLE) || rsp_valid) bad = 1'b1;
    end
    chk("stall held in ACCESS", {31'b0, bad}, 32'd0);
`endif

    // Reset asserted in ACCESS, away from any clock edge
    n_vec++;
    chk("pre-rst PENABLE", {31'b0, PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid-rst PSEL", {31'b0, PSEL}, 32'd0);
    chk("mid-rst PENABLE", {31'b0, PENABLE}, 32'd0);
    chk("mid-rst cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("mid-rst PADDR", PADDR, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge PCLK); #1;
      if (rsp_valid || PSEL || !cmd_ready) bad = 1'b1;
    end
    chk("post-rst quiet", {31'b0, bad}, 32'd0);

    // Still functional after the aborted transfer
    run_vec(8, vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 256, ACCESS-phase cycles without PREADY before abort; range 2..65535; used only with APB_CMD_MASTER_TIMEOUT_EN.
REQ-002 Port PCLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port PRESETn  input  1  asynchronous, active-low reset.
REQ-004 Port cmd_valid  input  1  command request.
REQ-005 Port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-006 Port cmd_addr  input  32  byte address.
REQ-007 Port cmd_write  input  1  1 = write, 0 = read.
REQ-008 Port cmd_wdata  input  32  write data.
REQ-009 Port rsp_valid  output  1  response available.
REQ-010 Port rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high at a clock edge.
REQ-011 Port rsp_rdata  output  32  read data; 0 for writes.
REQ-012 Port rsp_err  output  1  PSLVERR or timeout status.
REQ-013 Ports PSEL, PENABLE, PWRITE (output, 1 bit each); PADDR, PWDATA (output, 32 bits each); AMBA APB3 requester signals.
REQ-014 Ports PRDATA (input, 32 bits); PREADY, PSLVERR (input, 1 bit each); APB3 completer responses.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS, RESP; exactly one transfer in flight; no command queue.
REQ-016 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; on command handshake, register addr/write/wdata and go to SETUP.
REQ-017 SETUP (one cycle): PSEL=1, PENABLE=0; unconditional transition to ACCESS.
REQ-018 ACCESS: PSEL=1, PENABLE=1; stay while PREADY=0; on PREADY=1, capture PRDATA (reads only) and PSLVERR, then go to RESP.
REQ-019 PADDR = {captured addr[31:2], 2'b00}; PADDR, PWRITE and PWDATA are registered and stable from SETUP through the last ACCESS cycle; PWDATA=0 on reads.
REQ-020 RESP: PSEL=0, PENABLE=0, rsp_valid=1; rsp_rdata and rsp_err are held stable until handshake; on handshake go to IDLE.
REQ-021 Latency with a zero-wait completer: command handshake at edge N, PSEL rises after N, PENABLE rises after N+1, rsp_valid rises after N+2; at most one transfer per 4 cycles.
REQ-022 cmd_ready=0 in SETUP/ACCESS/RESP; cmd_valid there is ignored and not lost (requester holds it).
REQ-023 rsp_ready while rsp_valid=0 has no effect; PREADY/PSLVERR outside ACCESS are ignored.
REQ-024 PSLVERR=1 on the completing cycle sets rsp_err=1; for reads, rsp_rdata still carries PRDATA.

Reset
REQ-025 PRESETn low forces IDLE immediately: cmd_ready=1 once PRESETn is high (0 while in reset); PSEL=PENABLE=rsp_valid=rsp_err=0; PADDR=PWDATA=rsp_rdata=0; PWRITE=0; timeout counter=0.
REQ-026 Reset mid-transfer aborts it silently; no response is issued; the APB bus returns to idle within the reset assertion.

Configuration
REQ-027 Macro APB_CMD_MASTER_TIMEOUT_EN defined: counter runs in ACCESS; after TIMEOUT_CYCLES consecutive PREADY=0 cycles, go to RESP with rsp_err=1 and rsp_rdata=32'hFFFF_FFFF; PSEL/PENABLE drop the next cycle.
REQ-028 Macro undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Structure
REQ-029 Shared package apb_cmd_master_pkg holds the state enumeration, the timeout-abort read value 32'hFFFF_FFFF, and the APB data/address width constants (32).
REQ-030 One sub-module, apb_cmd_master_timer (load/count/expire), instantiated only under APB_CMD_MASTER_TIMEOUT_EN.

Verification
REQ-031 Zero-wait write: addr 0x10, wdata 0xA5A5_1234 -> SETUP with PADDR=0x10 and PWRITE=1, one ACCESS cycle, rsp_valid after 3 edges, rsp_err=0, rsp_rdata=0.
REQ-032 Read-back: read addr 0x13 against a memory completer holding 0xA5A5_1234 at word 0x10 -> PADDR=0x10, rsp_rdata=0xA5A5_1234.
REQ-033 Wait states: PREADY low for 5 cycles -> ACCESS lasts 6 cycles with PADDR/PWDATA stable; single response.
REQ-034 Error and back-pressure: PSLVERR=1 at completion with rsp_ready held low 4 cycles -> rsp_err=1 and data held; cmd_ready=0 until the response handshake.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=8): PREADY stuck low -> after 8 ACCESS cycles rsp_err=1, rsp_rdata=0xFFFF_FFFF, PSEL=0; macro off -> stays in ACCESS for 100+ cycles.
REQ-036 Reset in ACCESS: PRESETn low -> PSEL/PENABLE 0 without a clock edge; after release, no rsp_valid and cmd_ready=1.
